// File: rtl/pp_axi_rd_arb.sv
// Two-requester AXI read-port arbiter: requester 0 has priority, requester 1
// is protected by a starvation guard. An in-order tag FIFO records the owner
// of each issued burst so that returning R beats reach the right requester.
module pp_axi_rd_arb #(
  parameter int unsigned P_AW          = 32,
  parameter int unsigned P_DW          = 32,
  parameter int unsigned P_OUTSTANDING = 4,
  parameter int unsigned P_STARVE      = 3
) (
  input  logic            clk_core,
  input  logic            rst_x,

  input  logic            i_arvalid_0,
  output logic            o_arready_0,
  input  logic [P_AW-1:0] i_araddr_0,
  input  logic [3:0]      i_arlen_0,
  output logic            o_rvalid_0,
  output logic [P_DW-1:0] o_rdata_0,
  output logic            o_rlast_0,
  input  logic            i_rready_0,

  input  logic            i_arvalid_1,
  output logic            o_arready_1,
  input  logic [P_AW-1:0] i_araddr_1,
  input  logic [3:0]      i_arlen_1,
  output logic            o_rvalid_1,
  output logic [P_DW-1:0] o_rdata_1,
  output logic            o_rlast_1,
  input  logic            i_rready_1,

  output logic            o_arvalid_m,
  input  logic            i_arready_m,
  output logic [P_AW-1:0] o_araddr_m,
  output logic [3:0]      o_arlen_m,
  output logic [3:0]      o_arid_m,
  input  logic            i_rvalid_m,
  input  logic [P_DW-1:0] i_rdata_m,
  input  logic            i_rlast_m,
  output logic            o_rready_m
);

  localparam int unsigned PW = $clog2(P_OUTSTANDING);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = (P_STARVE < 1) ? 1 : $clog2(P_STARVE + 1);

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } ar_state_e;

  ar_state_e                state_q, state_d;
  logic [P_AW-1:0]          araddr_q, araddr_d;
  logic [3:0]               arlen_q, arlen_d;
  logic [3:0]               arid_q, arid_d;
  logic [SW-1:0]            starve_q, starve_d;
  logic [P_OUTSTANDING-1:0] tag_q, tag_d;
  logic [PW-1:0]            wptr_q, wptr_d;
  logic [PW-1:0]            rptr_q, rptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;

  logic nonempty;
  logic head;
  logic pop;
  logic full_eff;
  logic grant;
  logic sel1;

  // R routing to the owner at the FIFO head, plus grant decision
  always_comb begin
    nonempty    = (cnt_q != '0);
    head        = tag_q[rptr_q];
    o_rvalid_0  = nonempty && !head && i_rvalid_m;
    o_rvalid_1  = nonempty &&  head && i_rvalid_m;
    o_rlast_0   = nonempty && !head && i_rlast_m;
    o_rlast_1   = nonempty &&  head && i_rlast_m;
    o_rdata_0   = (nonempty && !head) ? i_rdata_m : '0;
    o_rdata_1   = (nonempty &&  head) ? i_rdata_m : '0;
    o_rready_m  = nonempty && (head ? i_rready_1 : i_rready_0);
    pop         = i_rvalid_m && o_rready_m && i_rlast_m;
    // a slot freed by this cycle's pop is usable by this cycle's grant
    full_eff    = (cnt_q == CW'(P_OUTSTANDING)) && !pop;
    sel1        = i_arvalid_1 && (!i_arvalid_0 || (starve_q == SW'(P_STARVE)));
    grant       = rst_x && (state_q == ST_IDLE) && !full_eff
                  && (i_arvalid_0 || i_arvalid_1);
    o_arready_0 = grant && !sel1;
    o_arready_1 = grant &&  sel1;
  end

  // Next-state: AR channel FSM, starvation counter, tag FIFO
  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arid_d   = arid_q;
    starve_d = starve_q;
    tag_d    = tag_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d  = ST_ISSUE;
          araddr_d = sel1 ? i_araddr_1 : i_araddr_0;
          arlen_d  = sel1 ? i_arlen_1 : i_arlen_0;
          arid_d   = {3'b000, sel1};
        end
      end
      ST_ISSUE: begin
        if (i_arready_m) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant) begin
      if (sel1 || !i_arvalid_1) starve_d = '0;
      else if (starve_q != SW'(P_STARVE)) starve_d = starve_q + 1'b1;
    end

    if (grant) begin
      tag_d[wptr_q] = sel1;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    if (grant && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !grant) cnt_d = cnt_q - 1'b1;
  end

  // State registers
  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      state_q  <= ST_IDLE;
      araddr_q <= '0;
      arlen_q  <= '0;
      arid_q   <= '0;
      starve_q <= '0;
      tag_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      arid_q   <= arid_d;
      starve_q <= starve_d;
      tag_q    <= tag_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_arvalid_m = (state_q == ST_ISSUE);
  assign o_araddr_m  = araddr_q;
  assign o_arlen_m   = arlen_q;
  assign o_arid_m    = arid_q;

endmodule

// File: tb/tb_pp_axi_rd_arb.sv
// Directed self-checking bench for pp_axi_rd_arb.
module tb_pp_axi_rd_arb;

  logic        clk_core = 1'b0;
  logic        rst_x;
  logic        i_arvalid_0, i_arvalid_1;
  logic        o_arready_0, o_arready_1;
  logic [31:0] i_araddr_0, i_araddr_1;
  logic [3:0]  i_arlen_0, i_arlen_1;
  logic        o_rvalid_0, o_rvalid_1;
  logic [31:0] o_rdata_0, o_rdata_1;
  logic        o_rlast_0, o_rlast_1;
  logic        i_rready_0, i_rready_1;
  logic        o_arvalid_m, i_arready_m;
  logic [31:0] o_araddr_m;
  logic [3:0]  o_arlen_m, o_arid_m;
  logic        i_rvalid_m, i_rlast_m, o_rready_m;
  logic [31:0] i_rdata_m;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pp_axi_rd_arb #(
    .P_AW(32), .P_DW(32), .P_OUTSTANDING(4), .P_STARVE(3)
  ) dut (
    .clk_core(clk_core), .rst_x(rst_x),
    .i_arvalid_0(i_arvalid_0), .o_arready_0(o_arready_0),
    .i_araddr_0(i_araddr_0), .i_arlen_0(i_arlen_0),
    .o_rvalid_0(o_rvalid_0), .o_rdata_0(o_rdata_0),
    .o_rlast_0(o_rlast_0), .i_rready_0(i_rready_0),
    .i_arvalid_1(i_arvalid_1), .o_arready_1(o_arready_1),
    .i_araddr_1(i_araddr_1), .i_arlen_1(i_arlen_1),
    .o_rvalid_1(o_rvalid_1), .o_rdata_1(o_rdata_1),
    .o_rlast_1(o_rlast_1), .i_rready_1(i_rready_1),
    .o_arvalid_m(o_arvalid_m), .i_arready_m(i_arready_m),
    .o_araddr_m(o_araddr_m), .o_arlen_m(o_arlen_m), .o_arid_m(o_arid_m),
    .i_rvalid_m(i_rvalid_m), .i_rdata_m(i_rdata_m),
    .i_rlast_m(i_rlast_m), .o_rready_m(o_rready_m)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // complete n bursts with single terminal beats
  task automatic drain(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      i_rvalid_m = 1'b1;
      i_rlast_m  = 1'b1;
      settle();
      chk("drain_rready", o_rready_m, 1'b1);
      step();
    end
    i_rvalid_m = 1'b0;
    i_rlast_m  = 1'b0;
  endtask

  logic exp_sel [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_x       = 1'b0;
    i_arvalid_0 = 1'b1;  // asserted during reset: must not be granted
    i_arvalid_1 = 1'b0;
    i_araddr_0  = '0;    i_araddr_1 = '0;
    i_arlen_0   = '0;    i_arlen_1  = '0;
    i_rready_0  = 1'b1;  i_rready_1 = 1'b1;
    i_arready_m = 1'b0;
    i_rvalid_m  = 1'b0;  i_rlast_m  = 1'b0;
    i_rdata_m   = 32'hDEAD_BEEF;

    // reset state
    step();
    settle();
    chk("rst_arvalid_m", o_arvalid_m, 1'b0);
    chk("rst_araddr_m", o_araddr_m, 32'h0);
    chk("rst_arid_m", o_arid_m, 4'h0);
    chk("rst_arready_0", o_arready_0, 1'b0);
    chk("rst_rready_m", o_rready_m, 1'b0);
    chk("rst_rdata_0", o_rdata_0, 32'h0);
    step();
    rst_x       = 1'b1;
    i_arvalid_0 = 1'b0;
    step();

    // T1: single request from requester 0
    i_arvalid_0 = 1'b1; i_araddr_0 = 32'h1000; i_arlen_0 = 4'd3;
    settle();
    chk("t1_arready_0", o_arready_0, 1'b1);
    chk("t1_arready_1", o_arready_1, 1'b0);
    chk("t1_arvalid_idle", o_arvalid_m, 1'b0);
    step();
    i_arvalid_0 = 1'b0; i_arready_m = 1'b1;
    settle();
    chk("t1_arvalid_m", o_arvalid_m, 1'b1);
    chk("t1_araddr", o_araddr_m, 32'h1000);
    chk("t1_arlen", o_arlen_m, 4'd3);
    chk("t1_arid", o_arid_m, 4'd0);
    step();
    i_arready_m = 1'b0;
    settle();
    chk("t1_arvalid_done", o_arvalid_m, 1'b0);
    for (int unsigned b = 0; b < 4; b++) begin
      i_rvalid_m = 1'b1; i_rdata_m = 32'hA0 + b; i_rlast_m = (b == 3);
      settle();
      chk("t1_rvalid_0", o_rvalid_0, 1'b1);
      chk("t1_rdata_0", o_rdata_0, 32'hA0 + b);
      chk("t1_rlast_0", o_rlast_0, (b == 3) ? 1'b1 : 1'b0);
      chk("t1_rvalid_1", o_rvalid_1, 1'b0);
      chk("t1_rready_m", o_rready_m, 1'b1);
      step();
    end
    i_rlast_m = 1'b0;
    settle();
    chk("t1_empty_rready", o_rready_m, 1'b0);
    chk("t1_empty_rvalid_0", o_rvalid_0, 1'b0);
    i_rvalid_m = 1'b0;

    // T2: both requesting continuously -> 0,0,0,1,0,0,0,1
    i_arvalid_0 = 1'b1; i_araddr_0 = 32'h2000; i_arlen_0 = 4'd0;
    i_arvalid_1 = 1'b1; i_araddr_1 = 32'h3000; i_arlen_1 = 4'd0;
    i_arready_m = 1'b1;
    for (int unsigned g = 0; g < 8; g++) begin
      settle();
      chk("t2_arready_0", o_arready_0, !exp_sel[g]);
      chk("t2_arready_1", o_arready_1, exp_sel[g]);
      step();
      i_rvalid_m = 1'b1; i_rlast_m = 1'b1;
      settle();
      chk("t2_arid", o_arid_m, {3'b000, exp_sel[g]});
      chk("t2_araddr", o_araddr_m, exp_sel[g] ? 32'h3000 : 32'h2000);
      chk("t2_no_grant_issue", o_arready_0 | o_arready_1, 1'b0);
      step();
      i_rvalid_m = 1'b0; i_rlast_m = 1'b0;
    end
    i_arvalid_0 = 1'b0; i_arvalid_1 = 1'b0;

    // T3: AR stall, fields held stable
    i_arready_m = 1'b0;
    i_arvalid_0 = 1'b1; i_araddr_0 = 32'h4000; i_arlen_0 = 4'd7;
    settle();
    chk("t3_grant", o_arready_0, 1'b1);
    step();
    i_araddr_0 = 32'h5000; i_arlen_0 = 4'd2;
    for (int unsigned c = 0; c < 5; c++) begin
      settle();
      chk("t3_arvalid", o_arvalid_m, 1'b1);
      chk("t3_araddr", o_araddr_m, 32'h4000);
      chk("t3_arlen", o_arlen_m, 4'd7);
      chk("t3_arid", o_arid_m, 4'd0);
      chk("t3_no_arready", o_arready_0, 1'b0);
      step();
    end
    i_arready_m = 1'b1;
    step();
    settle();
    chk("t3_regrant", o_arready_0, 1'b1);
    step();
    i_arvalid_0 = 1'b0;
    settle();
    chk("t3_araddr2", o_araddr_m, 32'h5000);
    step();
    drain(2);

    // T4: FIFO full blocks the 5th request until a burst completes
    i_arvalid_1 = 1'b1; i_araddr_1 = 32'h6000; i_arlen_1 = 4'd0;
    for (int unsigned g = 0; g < 4; g++) begin
      settle();
      chk("t4_fill_grant", o_arready_1, 1'b1);
      step();
      step();
    end
    settle();
    chk("t4_full_arready", o_arready_1, 1'b0);
    step();
    settle();
    chk("t4_full_arready2", o_arready_1, 1'b0);
    chk("t4_full_arvalid", o_arvalid_m, 1'b0);
    i_rvalid_m = 1'b1; i_rlast_m = 1'b1;
    settle();
    chk("t4_pop_rvalid_1", o_rvalid_1, 1'b1);
    chk("t4_pop_grant", o_arready_1, 1'b1);
    step();
    i_rvalid_m = 1'b0; i_rlast_m = 1'b0; i_arvalid_1 = 1'b0;
    step();
    drain(4);

    // T5: interleaved owners 0,1,0; requester 1 back-pressures
    i_arvalid_0 = 1'b1; i_araddr_0 = 32'h7000; i_arlen_0 = 4'd1;
    step(); i_arvalid_0 = 1'b0; step();
    i_arvalid_1 = 1'b1; i_araddr_1 = 32'h8000; i_arlen_1 = 4'd1;
    settle();
    chk("t5_grant_1", o_arready_1, 1'b1);
    step(); i_arvalid_1 = 1'b0; step();
    i_arvalid_0 = 1'b1; i_araddr_0 = 32'h9000; i_arlen_0 = 4'd0;
    step(); i_arvalid_0 = 1'b0; step();
    for (int unsigned b = 0; b < 2; b++) begin
      i_rvalid_m = 1'b1; i_rdata_m = 32'h10 + b; i_rlast_m = (b == 1);
      settle();
      chk("t5_b1_rvalid_0", o_rvalid_0, 1'b1);
      chk("t5_b1_rdata_0", o_rdata_0, 32'h10 + b);
      step();
    end
    i_rready_1 = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      i_rvalid_m = 1'b1; i_rdata_m = 32'h55; i_rlast_m = (c != 0);
      settle();
      chk("t5_stall_rready_m", o_rready_m, 1'b0);
      chk("t5_stall_rvalid_1", o_rvalid_1, 1'b1);
      chk("t5_stall_rvalid_0", o_rvalid_0, 1'b0);
      step();
    end
    i_rready_1 = 1'b1;
    settle();
    chk("t5_release_rready", o_rready_m, 1'b1);
    step();
    i_rdata_m = 32'h77; i_rlast_m = 1'b1;
    settle();
    chk("t5_b3_rvalid_0", o_rvalid_0, 1'b1);
    chk("t5_b3_rdata_0", o_rdata_0, 32'h77);
    chk("t5_b3_rvalid_1", o_rvalid_1, 1'b0);
    step();
    i_rvalid_m = 1'b0; i_rlast_m = 1'b0;
    settle();
    chk("t5_empty", o_rready_m, 1'b0);

    // T6: reset mid-burst
    i_arvalid_0 = 1'b1; i_araddr_0 = 32'hA000; i_arlen_0 = 4'd3;
    step(); i_arvalid_0 = 1'b0; step();
    i_rvalid_m = 1'b1; i_rlast_m = 1'b0; i_rdata_m = 32'h99;
    i_arvalid_1 = 1'b1; i_araddr_1 = 32'hB000; i_arlen_1 = 4'd5;
    settle();
    chk("t6_beat_rvalid_0", o_rvalid_0, 1'b1);
    chk("t6_grant_1", o_arready_1, 1'b1);
    step();
    i_arready_m = 1'b0;
    settle();
    chk("t6_issue_pending", o_arvalid_m, 1'b1);
    rst_x = 1'b0;
    #1;
    chk("t6_rst_arvalid", o_arvalid_m, 1'b0);
    chk("t6_rst_araddr", o_araddr_m, 32'h0);
    chk("t6_rst_arlen", o_arlen_m, 4'h0);
    chk("t6_rst_arid", o_arid_m, 4'h0);
    chk("t6_rst_rvalid_0", o_rvalid_0, 1'b0);
    chk("t6_rst_rdata_0", o_rdata_0, 32'h0);
    chk("t6_rst_rready_m", o_rready_m, 1'b0);
    chk("t6_rst_arready_1", o_arready_1, 1'b0);
    step();
    i_rvalid_m = 1'b0;
    rst_x = 1'b1;
    settle();
    chk("t6_post_grant", o_arready_1, 1'b1);
    step();
    i_arvalid_1 = 1'b0; i_arready_m = 1'b1;
    settle();
    chk("t6_post_arid", o_arid_m, 4'd1);
    chk("t6_post_araddr", o_araddr_m, 32'hB000);
    step();
    i_arready_m = 1'b0;
    i_rvalid_m = 1'b1; i_rlast_m = 1'b1; i_rdata_m = 32'h42;
    settle();
    chk("t6_post_rvalid_1", o_rvalid_1, 1'b1);
    chk("t6_post_rvalid_0", o_rvalid_0, 1'b0);
    chk("t6_post_rdata_1", o_rdata_1, 32'h42);
    step();
    settle();
    chk("t6_post_empty", o_rready_m, 1'b0);
    i_rvalid_m = 1'b0; i_rlast_m = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
